// File: rtl/muldiv.sv
// -----------------------------------------------------------------------------
// muldiv -- iterative RV32M multiply/divide unit.
//
// Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time.
// Multiplies use a 32-step shift-add on operand magnitudes; divides use a
// 32-step restoring divider on magnitudes. Signs are re-applied on the final
// step. Divide-by-zero and signed overflow are resolved at accept time and
// skip the iterative phase entirely.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   req_valid  request from the execute stage
//   req_ready  high while idle; a request is taken when valid & ready & !flush
//   funct3     RV32M operation select
//   rs1_data   operand A (dividend / multiplicand)
//   rs2_data   operand B (divisor / multiplier)
//   rd         destination register number
//   flush      kills any in-flight operation and blocks an accept
//   wb_wen     one-cycle register-file write strobe (suppressed for rd = 0)
//   wb_rd      write-back register number (holds outside the strobe)
//   wb_data    write-back result (holds outside the strobe)
// -----------------------------------------------------------------------------
module muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            wb_wen,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Captured request
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [4:0]      cnt;
  logic            neg_q;   // negate product / quotient
  logic            neg_r;   // negate remainder (sign of dividend)

  // Multiplier datapath
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] prod;

  // Divider datapath
  logic [XLEN-1:0] quo;     // starts as dividend, shifts quotient bits in
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_div;
  logic            signed_a, signed_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE) && !flush;
  assign is_div    = funct3[2];

  // MUL/MULH/MULHSU treat A as signed, only MUL/MULH treat B as signed;
  // DIV/REM are fully signed, DIVU/REMU fully unsigned.
  assign signed_a = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign signed_b = is_div ? !funct3[0] : !funct3[1];
  assign a_neg    = signed_a && rs1_data[XLEN-1];
  assign b_neg    = signed_b && rs2_data[XLEN-1];
  // The most negative value maps onto itself, which is still the correct
  // unsigned magnitude.
  assign a_mag    = a_neg ? -rs1_data : rs1_data;
  assign b_mag    = b_neg ? -rs2_data : rs2_data;

  assign div_zero = (rs2_data == '0);
  assign div_ovf  = !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_data == '1);
  assign special  = is_div && (div_zero || div_ovf);

  always_comb begin
    if (funct3[1]) special_res = div_zero ? rs1_data : '0;                  // REM/REMU
    else           special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}}; // DIV/DIVU
  end

  // ---------------------------------------------------------------------------
  // One iteration step, shared by the register update and the final result
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] mul_sum;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   rem_step, quo_step;
  logic [XLEN-1:0]   quo_fin, rem_fin, mul_res, result;

  assign mul_sum   = prod + (mplier[0] ? mcand : '0);
  assign div_shift = {rem, quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvsr};
  // Borrow out means the trial subtraction failed: restore.
  assign rem_step  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign quo_step  = {quo[XLEN-2:0], ~div_diff[XLEN]};

  assign prod_fin  = neg_q ? -mul_sum : mul_sum;
  assign mul_res   = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  assign quo_fin   = neg_q ? -quo_step : quo_step;
  assign rem_fin   = neg_r ? -rem_step : rem_step;
  assign result    = op_q[2] ? (op_q[1] ? rem_fin : quo_fin) : mul_res;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is a flop, so it takes a non-blocking assignment; blocking
    // here would let same-edge readers see the new value and race.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    wb_wen    = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = special ? DONE : BUSY;
      BUSY: if (cnt == 5'd31) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        wb_wen    = (rd_q != 5'd0);
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      wb_wen    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and write-back registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the datapath is cleared on reset too, so a post-reset wb_data
    // and every accumulator read back as a defined zero rather than X.
    if (!rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        op_q   <= funct3;
        rd_q   <= rd;
        cnt    <= '0;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        mcand  <= {{XLEN{1'b0}}, a_mag};
        mplier <= b_mag;
        prod   <= '0;
        quo    <= a_mag;
        rem    <= '0;
        dvsr   <= b_mag;
      end else if (state == BUSY) begin
        // Both engines step every cycle; op_q picks which result is kept.
        cnt    <= cnt + 5'd1;
        mcand  <= {mcand[2*XLEN-2:0], 1'b0};
        mplier <= {1'b0, mplier[XLEN-1:1]};
        prod   <= mul_sum;
        quo    <= quo_step;
        rem    <= rem_step;
      end

      // Load the write-back registers only when DONE is really entered, so a
      // flush on the last iteration leaves them untouched.
      if (state_nxt == DONE) begin
        if (state == IDLE) begin
          wb_rd   <= rd;
          wb_data <= special_res;
        end else begin
          wb_rd   <= rd_q;
          wb_data <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// -----------------------------------------------------------------------------
// tb_muldiv -- self-checking bench for muldiv.
// Each scenario task drives requests, observes write-back and ready timing,
// and compares against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd        (rd),
    .flush     (flush),
    .wb_wen    (wb_wen),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: RV32M semantics with plain 64-bit / signed arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = (f != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (f <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    case (f)
      3'd0:    return p[31:0];
      3'd1,
      3'd2,
      3'd3:    return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                               : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
    return f[2] && ((b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Issue one request and observe 40 cycles after the accepting edge.
  // Called and returns at posedge+1. Cycle c = sample after c-th edge past accept.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        output int wen_at, output int n_wen,
                        output logic [31:0] data, output logic [4:0] wrd,
                        output int ready_at);
    int w;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: req_ready still 0 after %0d cycles", w);
    end
    req_valid = 1'b1;
    funct3    = f;
    rs1_data  = a;
    rs2_data  = b;
    rd        = r;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wen_at    = -1;
    n_wen     = 0;
    ready_at  = -1;
    data      = 'x;
    wrd       = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (wb_wen) begin
        n_wen++;
        if (wen_at < 0) begin
          wen_at = c;
          data   = wb_data;
          wrd    = wb_rd;
        end
      end
      if (req_ready && ready_at < 0) ready_at = c;
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    funct3    = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    rd        = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wb_wen !== 1'b0)  begin n_err++; $display("FAIL reset_wen: got %b want 0", wb_wen); end
    n_cmp++; if (wb_rd !== 5'd0)   begin n_err++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", wb_data); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_mul_basic();
    int wen_at, n_wen, ready_at;
    logic [31:0] data;
    logic [4:0]  wrd;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, wen_at, n_wen, data, wrd, ready_at);
    n_cmp++; if (wen_at != 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", wen_at); end
    n_cmp++; if (n_wen != 1)   begin n_err++; $display("FAIL mul_nwen: got %0d want 1", n_wen); end
    n_cmp++; if (data !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_data: got %h want ffffffeb", data); end
    n_cmp++; if (wrd !== 5'd5) begin n_err++; $display("FAIL mul_rd: got %0d want 5", wrd); end
    // ready first seen at 34 means it was low for all of BUSY and DONE
    n_cmp++; if (ready_at != 34) begin n_err++; $display("FAIL mul_ready_at: got %0d want 34", ready_at); end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    int wen_at, n_wen, ready_at;
    logic [31:0] data;
    logic [4:0]  wrd, r;
    v[0] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    v[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    v[2] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    v[3] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    v[4] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    v[5] = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
    v[6] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    v[7] = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
    v[8] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[9] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    foreach (v[i]) begin
      r = 5'($urandom_range(1, 31));
      run_op(v[i].f, v[i].a, v[i].b, r, wen_at, n_wen, data, wrd, ready_at);
      n_cmp++; if (data !== v[i].exp) begin n_err++; $display("FAIL dir%0d_data: got %h want %h", i, data, v[i].exp); end
      n_cmp++; if (wen_at != v[i].lat) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, wen_at, v[i].lat); end
      n_cmp++; if (wrd !== r) begin n_err++; $display("FAIL dir%0d_rd: got %0d want %0d", i, wrd, r); end
      n_cmp++; if (ready_at != v[i].lat + 1) begin n_err++; $display("FAIL dir%0d_ready_at: got %0d want %0d", i, ready_at, v[i].lat + 1); end
    end
  endtask

  task automatic test_rd_zero();
    int wen_at, n_wen, ready_at;
    logic [31:0] data;
    logic [4:0]  wrd;
    run_op(3'd0, $urandom, $urandom, 5'd0, wen_at, n_wen, data, wrd, ready_at);
    n_cmp++; if (n_wen != 0) begin n_err++; $display("FAIL rd0_nwen: got %0d want 0", n_wen); end
    n_cmp++; if (ready_at != 34) begin n_err++; $display("FAIL rd0_ready_at: got %0d want 34", ready_at); end
  endtask

  // Abort at BUSY cycle 10 via flush (use_rst=0) or reset (use_rst=1),
  // then confirm nothing is written and a fresh op completes correctly.
  task automatic test_abort(input bit use_rst);
    int wen_at, n_wen, ready_at, stray;
    logic [31:0] data, a, b, exp;
    logic [4:0]  wrd;
    string       tag;
    tag = use_rst ? "rst_mid" : "flush";
    req_valid = 1'b1;
    funct3    = 3'd1;
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    rd        = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b0; else flush = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b1;
    flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %b want 1", tag, req_ready); end
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      if (wb_wen) stray++;
      @(posedge clk); #1;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL %s_stray_wen: got %0d want 0", tag, stray); end
    a   = $urandom;
    b   = $urandom | 32'd1;
    exp = ref_result(3'd4, a, b);
    run_op(3'd4, a, b, 5'd12, wen_at, n_wen, data, wrd, ready_at);
    n_cmp++; if (data !== exp) begin n_err++; $display("FAIL %s_next_data: got %h want %h", tag, data, exp); end
    n_cmp++; if (wen_at != 33) begin n_err++; $display("FAIL %s_next_latency: got %0d want 33", tag, wen_at); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    logic [31:0] d[2];
    logic [4:0]  r[2];
    int          at[2];
    int          n_wen;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom | 32'd1;
    e1 = ref_result(3'd3, a1, b1);
    e2 = ref_result(3'd5, a2, b2);
    req_valid = 1'b1;
    funct3 = 3'd3; rs1_data = a1; rs2_data = b1; rd = 5'd3;
    @(posedge clk); #1;
    // keep requesting with a second op: must wait until the unit is idle
    funct3 = 3'd5; rs1_data = a2; rs2_data = b2; rd = 5'd4;
    n_wen = 0;
    for (int c = 1; c <= 80; c++) begin
      if (wb_wen) begin
        if (n_wen < 2) begin at[n_wen] = c; d[n_wen] = wb_data; r[n_wen] = wb_rd; end
        n_wen++;
      end
      if (c == 35) begin
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready35: got %b want 0", req_ready); end
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (n_wen != 2) begin n_err++; $display("FAIL b2b_nwen: got %0d want 2", n_wen); end
    if (n_wen >= 2) begin
      n_cmp++; if (at[0] != 33) begin n_err++; $display("FAIL b2b_at1: got %0d want 33", at[0]); end
      n_cmp++; if (d[0] !== e1 || r[0] !== 5'd3) begin n_err++; $display("FAIL b2b_op1: got %h/%0d want %h/3", d[0], r[0], e1); end
      n_cmp++; if (at[1] != 67) begin n_err++; $display("FAIL b2b_at2: got %0d want 67", at[1]); end
      n_cmp++; if (d[1] !== e2 || r[1] !== 5'd4) begin n_err++; $display("FAIL b2b_op2: got %h/%0d want %h/4", d[1], r[1], e2); end
    end
  endtask

  task automatic test_random();
    int wen_at, n_wen, ready_at, lat;
    logic [31:0] data, a, b, exp;
    logic [4:0]  wrd, r;
    logic [2:0]  f;
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      r   = 5'($urandom_range(0, 31));
      exp = ref_result(f, a, b);
      lat = ref_fast(f, a, b) ? 1 : 33;
      run_op(f, a, b, r, wen_at, n_wen, data, wrd, ready_at);
      n_cmp++; if (ready_at != lat + 1) begin n_err++; $display("FAIL rnd%0d_ready_at: got %0d want %0d", i, ready_at, lat + 1); end
      if (r == 5'd0) begin
        n_cmp++; if (n_wen != 0) begin n_err++; $display("FAIL rnd%0d_nwen: got %0d want 0", i, n_wen); end
      end else begin
        n_cmp++; if (wen_at != lat || n_wen != 1) begin n_err++; $display("FAIL rnd%0d_latency: got %0d x%0d want %0d x1", i, wen_at, n_wen, lat); end
        n_cmp++; if (data !== exp) begin n_err++; $display("FAIL rnd%0d_data f=%0d a=%h b=%h: got %h want %h", i, f, a, b, data, exp); end
        n_cmp++; if (wrd !== r) begin n_err++; $display("FAIL rnd%0d_rd: got %0d want %0d", i, wrd, r); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_directed();
    test_rd_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
